// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package pc_fetch_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IF_ID_W  = 1 + XLEN + XLEN + XLEN + 1;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_MEM = 2'd2,
    DRAIN    = 2'd3
  } fetch_state_e;

  // IF/ID payload: 98 bits, valid in the MSB.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
  } if_id_t;

  // Empty pipeline slot carrying the bubble instruction.
  function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b            = '0;
    b.inst       = nop;
    return b;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush.
module if_id_reg
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Flush beats load; neither asserted means hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= if_id_bubble(NOP_INST);
    end else if (flush) begin
      q <= if_id_bubble(NOP_INST);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch front end: PC register, fetch FSM and IF/ID register.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] predict_PC,
  input  logic            istaken,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_if,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pred_pc,
  output logic            if_id_pred_taken
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic            ifid_load, ifid_flush;
  if_id_t          ifid_d, ifid_q;

  // State, PC and request flag; request is high in every state but IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      imem_req <= (state_d != IDLE);
    end
  end

  // Next state, next PC and IF/ID control; redirect > wait > stall > advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;

    if (ex_redirect) begin
      pc_d       = {ex_redirect_pc[XLEN-1:2], 2'b00};
      ifid_flush = 1'b1;
      if ((state_q == DRAIN) || ((state_q == WAIT_MEM) && !imem_ready)) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH, WAIT_MEM: begin
          if (imem_ready) begin
            state_d = FETCH;
            if (!stall_if) begin
              ifid_load = 1'b1;
              pc_d      = predict_PC;
            end
          end else begin
            state_d    = WAIT_MEM;
            ifid_flush = !stall_if;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Payload captured when an instruction is latched.
  always_comb begin
    ifid_d            = '0;
    ifid_d.valid      = 1'b1;
    ifid_d.inst       = imem_rdata;
    ifid_d.pc         = pc;
    ifid_d.pred_pc    = predict_PC;
    ifid_d.pred_taken = istaken;
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr        = pc;
  assign if_id_valid      = ifid_q.valid;
  assign if_id_inst       = ifid_q.inst;
  assign if_id_pc         = ifid_q.pc;
  assign if_id_pred_pc    = ifid_q.pred_pc;
  assign if_id_pred_taken = ifid_q.pred_taken;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl against a cycle-level behavioural model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RDMASK = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, predict_PC, imem_addr, imem_rdata, ex_redirect_pc;
  logic [31:0] if_id_inst, if_id_pc, if_id_pred_pc;
  logic        istaken, imem_req, imem_ready, stall_if, ex_redirect;
  logic        if_id_valid, if_id_pred_taken;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: architectural view of the fetch unit.
  logic [31:0] m_pc, m_inst, m_ipc, m_ppc;
  logic        m_v, m_pt;
  bit          m_idle;      // first cycle after reset, no request yet
  bit          m_miss;      // an access has been outstanding since an earlier cycle
  bit          m_discard;   // an abandoned access must complete before refetch

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .predict_PC(predict_PC), .istaken(istaken),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .stall_if(stall_if), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
    .if_id_pc(if_id_pc), .if_id_pred_pc(if_id_pred_pc), .if_id_pred_taken(if_id_pred_taken)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_v = 1'b0; m_inst = NOP; m_ipc = '0; m_ppc = '0; m_pt = 1'b0;
    m_idle = 1'b1; m_miss = 1'b0; m_discard = 1'b0;
  endtask

  task automatic model_bubble();
    m_v = 1'b0; m_inst = NOP; m_ipc = '0; m_ppc = '0; m_pt = 1'b0;
  endtask

  // Drive one cycle of inputs, advance model across the edge, return 1ns after the edge.
  task automatic step(input bit rdy, input bit stl, input bit rd, input logic [31:0] rpc,
                      input bit tk, input logic [31:0] tgt);
    imem_ready     = rdy;
    stall_if       = stl;
    ex_redirect    = rd;
    ex_redirect_pc = rpc;
    istaken        = tk;
    predict_PC     = tk ? tgt : m_pc + 32'd4;
    imem_rdata     = m_pc ^ RDMASK;
    @(posedge clk);
    if (rd) begin
      m_discard = m_discard || (m_miss && !rdy);
      m_miss    = 1'b0;
      m_idle    = 1'b0;
      m_pc      = rpc & 32'hFFFF_FFFC;
      model_bubble();
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_discard) begin
      if (rdy) m_discard = 1'b0;
    end else if (rdy) begin
      m_miss = 1'b0;
      if (!stl) begin
        m_v = 1'b1; m_inst = m_pc ^ RDMASK; m_ipc = m_pc; m_ppc = predict_PC; m_pt = tk;
        m_pc = predict_PC;
      end
    end else begin
      m_miss = 1'b1;
      if (!stl) model_bubble();
    end
    #1;
  endtask

  task automatic hit(); step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ready = 1'b1; stall_if = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0;
    istaken = 1'b0; predict_PC = 32'h4; imem_rdata = RDMASK;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({imem_req, pc, if_id_valid, if_id_inst, if_id_pc, if_id_pred_pc, if_id_pred_taken} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got req=%0b pc=%h v=%0b inst=%h expected req=0 pc=0 v=0 inst=%h",
               imem_req, pc, if_id_valid, if_id_inst, NOP);
    end
    reset = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got imem_req=%0b expected 0", imem_req);
    end
    hit();
    n_checks++;
    if (imem_req !== 1'b1 || pc !== 32'h0 || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch: got req=%0b pc=%h v=%0b expected req=1 pc=0 v=0", imem_req, pc, if_id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      hit();
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(i * 4) || if_id_inst !== (32'(i * 4) ^ RDMASK)) begin
        n_fail++;
        $display("FAIL seq_fetch_%0d: got v=%0b pc=%h inst=%h expected v=1 pc=%h", i, if_id_valid,
                 if_id_pc, if_id_inst, 32'(i * 4));
      end
    end
    hit();
  endtask

  task automatic test_taken();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    n_checks++;
    if ({if_id_valid, if_id_pc, if_id_pred_pc, if_id_pred_taken, pc} !== {1'b1, 32'h10, 32'h40, 1'b1, 32'h40}) begin
      n_fail++;
      $display("FAIL taken: got v=%0b pc=%h pred=%h tk=%0b next=%h expected 1 10 40 1 40",
               if_id_valid, if_id_pc, if_id_pred_pc, if_id_pred_taken, pc);
    end
    hit();
    n_checks++;
    if (if_id_pc !== 32'h40 || if_id_pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL taken_target: got pc=%h tk=%0b expected 40 0", if_id_pc, if_id_pred_taken);
    end
  endtask

  task automatic test_miss();
    step(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      n_checks++;
      if (if_id_valid !== 1'b0 || if_id_inst !== NOP || pc !== 32'h20 || imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL miss_bubble_%0d: got v=%0b inst=%h pc=%h req=%0b expected 0 %h 20 1",
                 i, if_id_valid, if_id_inst, pc, imem_req, NOP);
      end
    end
    hit();
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h20 || pc !== 32'h24) begin
      n_fail++;
      $display("FAIL miss_return: got v=%0b ifpc=%h pc=%h expected 1 20 24", if_id_valid, if_id_pc, pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_ifpc;
    held_pc = pc; held_ifpc = if_id_pc;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n_checks++;
      if (pc !== held_pc || if_id_pc !== held_ifpc || if_id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got pc=%h ifpc=%h v=%0b expected %h %h 1",
                 i, pc, if_id_pc, if_id_valid, held_pc, held_ifpc);
      end
    end
    hit();
    n_checks++;
    if (if_id_pc !== held_pc) begin
      n_fail++;
      $display("FAIL stall_release: got ifpc=%h expected %h", if_id_pc, held_pc);
    end
    hit();
    n_checks++;
    if (if_id_pc !== held_pc + 32'd4) begin
      n_fail++;
      $display("FAIL stall_next: got ifpc=%h expected %h", if_id_pc, held_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    step(1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
    n_checks++;
    if (pc !== 32'h100 || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_wait: got pc=%h v=%0b expected 100 0", pc, if_id_valid);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (if_id_valid !== 1'b0 || pc !== 32'h100) begin
      n_fail++;
      $display("FAIL drain_discard: got v=%0b ifpc=%h pc=%h expected v=0 pc=100", if_id_valid, if_id_pc, pc);
    end
    hit();
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_inst !== (32'h100 ^ RDMASK)) begin
      n_fail++;
      $display("FAIL drain_first: got v=%0b ifpc=%h inst=%h expected 1 100 %h",
               if_id_valid, if_id_pc, if_id_inst, 32'h100 ^ RDMASK);
    end
  endtask

  task automatic test_redirect_stall();
    step(1'b1, 1'b1, 1'b1, 32'h202, 1'b0, 32'h0);
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_inst !== NOP || pc !== 32'h200) begin
      n_fail++;
      $display("FAIL redir_stall: got v=%0b inst=%h pc=%h expected 0 %h 200", if_id_valid, if_id_inst, pc, NOP);
    end
    hit();
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({imem_req, pc, if_id_valid, if_id_inst, if_id_pc, if_id_pred_pc, if_id_pred_taken} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got req=%0b pc=%h v=%0b inst=%h ifpc=%h expected 0 0 0 %h 0",
               imem_req, pc, if_id_valid, if_id_inst, if_id_pc, NOP);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] tgt, rpc;
    bit rdy, stl, rd, tk;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(9) < 7);
      stl = ($urandom_range(9) < 2);
      rd  = ($urandom_range(99) < 8);
      tk  = ($urandom_range(3) == 0);
      tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
      rpc = $urandom;
      step(rdy, stl, rd, rpc, tk, tgt);
      n_checks++;
      if ({imem_req, pc, if_id_valid, if_id_inst, if_id_pc, if_id_pred_pc, if_id_pred_taken} !==
          {!m_idle, m_pc, m_v, m_inst, m_ipc, m_ppc, m_pt}) begin
        n_fail++;
        $display("FAIL random_%0d: got req=%0b pc=%h v=%0b inst=%h ifpc=%h pp=%h tk=%0b expected req=%0b pc=%h v=%0b inst=%h ifpc=%h pp=%h tk=%0b",
                 i, imem_req, pc, if_id_valid, if_id_inst, if_id_pc, if_id_pred_pc, if_id_pred_taken,
                 !m_idle, m_pc, m_v, m_inst, m_ipc, m_ppc, m_pt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_miss();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
